// File: rtl/pe_out_packer.sv
// pe_out_packer
//   Packs signed inner-product results from the parallel PE array into
//   512-bit output lines of 32 x 16-bit lanes. Each result is requantized
//   (arithmetic right shift by cfg_shift, then signed 16-bit saturation)
//   and written to the next free lane. A full line, or a partial line on
//   flush, is pushed into a 2-entry output FIFO. When the FIFO is full the
//   completed line waits in the pack register (pending) and any result that
//   arrives meanwhile is dropped and reported through the sticky overflow.
//
//   Build option: define PE_OUT_RELU_EN to add a ReLU stage (enabled at run
//   time by cfg_relu) that clamps negative results to zero before
//   saturation. Without the macro cfg_relu has no effect.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   result_i   in   32   signed inner-product result
//   vld_i      in   1    result_i valid (single-cycle pulse, no backpressure)
//   flush      in   1    emit the current partial line
//   cfg_shift  in   5    requantization right-shift amount
//   cfg_relu   in   1    ReLU enable (PE_OUT_RELU_EN builds only)
//   out_data   out  512  packed line, lane k at [16k+15:16k]
//   out_cnt    out  6    number of valid lanes, 1..32
//   out_vld    out  1    out_data/out_cnt valid
//   out_rdy    in   1    consumer accepts the line on out_vld && out_rdy
//   overflow   out  1    sticky: a result was dropped
module pe_out_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  result_i,
    input  logic         vld_i,
    input  logic         flush,
    input  logic [4:0]   cfg_shift,
    input  logic         cfg_relu,
    output logic [511:0] out_data,
    output logic [5:0]   out_cnt,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic         overflow
);

    logic [511:0] pack_data;
    logic [5:0]   lane_cnt;
    logic         pending;

    logic [511:0] fifo_data [0:1];
    logic [5:0]   fifo_cnt  [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   fifo_count;

    logic signed [31:0] shifted;
    logic [15:0]        q;

    logic [511:0] line_acc;
    logic [5:0]   cnt_acc;
    logic         line_done;
    logic         pop;
    logic         space;
    logic         push;

    // Requantization: arithmetic shift, optional ReLU, signed saturation.
    always_comb begin
        shifted = $signed(result_i) >>> cfg_shift;
`ifdef PE_OUT_RELU_EN
        if (cfg_relu && (shifted < 32'sd0)) begin
            shifted = 32'sd0;
        end
`endif
        if (shifted > 32'sd32767) begin
            q = 16'h7FFF;
        end else if (shifted < -32'sd32768) begin
            q = 16'h8000;
        end else begin
            q = shifted[15:0];
        end
    end

`ifndef PE_OUT_RELU_EN
    logic unused_cfg_relu;
    assign unused_cfg_relu = cfg_relu;
`endif

    // While pending, the pack register already holds a finished line and the
    // incoming result is dropped, so line_acc/cnt_acc simply carry it along.
    // Otherwise the new result is packed first and flush then sees L+1 lanes.
    always_comb begin
        pop      = (fifo_count != 2'd0) && out_rdy;
        space    = (fifo_count != 2'd2) || pop;
        line_acc = pack_data;
        cnt_acc  = lane_cnt;
        if (!pending && vld_i) begin
            line_acc[{lane_cnt[4:0], 4'b0000} +: 16] = q;
            cnt_acc = lane_cnt + 6'd1;
        end
        line_done = pending || (cnt_acc == 6'd32) || (flush && (cnt_acc != 6'd0));
        push      = line_done && space;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_data    <= '0;
            lane_cnt     <= 6'd0;
            pending      <= 1'b0;
            overflow     <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_cnt[0]  <= 6'd0;
            fifo_cnt[1]  <= 6'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= 2'd0;
        end else begin
            if (vld_i && pending) begin
                overflow <= 1'b1;
            end

            // Clearing the pack register on push keeps the unused upper
            // lanes of the next partial line at zero.
            if (push) begin
                fifo_data[wr_ptr] <= line_acc;
                fifo_cnt[wr_ptr]  <= cnt_acc;
                wr_ptr            <= ~wr_ptr;
                pack_data         <= '0;
                lane_cnt          <= 6'd0;
                pending           <= 1'b0;
            end else begin
                pack_data <= line_acc;
                lane_cnt  <= cnt_acc;
                pending   <= line_done;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_vld  = (fifo_count != 2'd0);
    assign out_data = out_vld ? fifo_data[rd_ptr] : '0;
    assign out_cnt  = out_vld ? fifo_cnt[rd_ptr]  : 6'd0;

endmodule

// File: tb/tb_pe_out_packer.sv
module tb_pe_out_packer;

    logic         clk;
    logic         rst;
    logic [31:0]  result_i;
    logic         vld_i;
    logic         flush;
    logic [4:0]   cfg_shift;
    logic         cfg_relu;
    logic [511:0] out_data;
    logic [5:0]   out_cnt;
    logic         out_vld;
    logic         out_rdy;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_line;
    logic [511:0] exp_lines [0:2];

    pe_out_packer dut (
        .clk       (clk),
        .rst       (rst),
        .result_i  (result_i),
        .vld_i     (vld_i),
        .flush     (flush),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val);
        result_i = val;
        vld_i    = 1'b1;
        step();
        vld_i    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst       = 1'b1;
        result_i  = '0;
        vld_i     = 1'b0;
        flush     = 1'b0;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        out_rdy   = 1'b1;
        step();
        step();

        // Reset state
        check("rst_out_vld",  {511'd0, out_vld},  512'd0);
        check("rst_out_data", out_data,           512'd0);
        check("rst_out_cnt",  {506'd0, out_cnt},  512'd0);
        check("rst_overflow", {511'd0, overflow}, 512'd0);
        rst = 1'b0;
        step();

        // Full line: k<<4 shifted by 4 gives lane value k
        cfg_shift = 5'd4;
        exp_line  = '0;
        for (int k = 0; k < 32; k++) begin
            exp_line[16*k +: 16] = 16'(k);
            send(32'(k) << 4);
            if (k == 30) check("full_no_vld_early", {511'd0, out_vld}, 512'd0);
        end
        check("full_out_vld",  {511'd0, out_vld}, 512'd1);
        check("full_out_cnt",  {506'd0, out_cnt}, 512'd32);
        check("full_out_data", out_data, exp_line);
        step();
        check("full_popped", {511'd0, out_vld}, 512'd0);

        // Saturation and ReLU, emitted as a 3-lane partial line
        out_rdy   = 1'b0;
        cfg_shift = 5'd0;
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        cfg_relu = 1'b1;
        send(32'hFFFF_FFFB);
        cfg_relu = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_line = '0;
        exp_line[15:0]  = 16'h7FFF;
        exp_line[31:16] = 16'h8000;
`ifdef PE_OUT_RELU_EN
        exp_line[47:32] = 16'h0000;
`else
        exp_line[47:32] = 16'hFFFB;
`endif
        check("sat_out_cnt",  {506'd0, out_cnt}, 512'd3);
        check("sat_out_data", out_data, exp_line);
        out_rdy = 1'b1;
        step();
        check("sat_popped", {511'd0, out_vld}, 512'd0);

        // Five results with shift 2 then flush
        cfg_shift = 5'd2;
        send(-32'sd1000);
        send(32'd400);
        send(32'd100000);
        send(32'd200000);
        send(-32'sd400000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_line = '0;
        exp_line[15:0]  = 16'hFF06;
        exp_line[31:16] = 16'h0064;
        exp_line[47:32] = 16'h61A8;
        exp_line[63:48] = 16'h7FFF;
        exp_line[79:64] = 16'h8000;
        check("flush5_out_cnt",  {506'd0, out_cnt}, 512'd5);
        check("flush5_out_data", out_data, exp_line);
        // Flush with an empty line is a no-op; the line above pops here
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty_noop", {511'd0, out_vld}, 512'd0);

        // Flush coincident with the 6th result
        cfg_shift = 5'd0;
        exp_line  = '0;
        for (int k = 0; k < 5; k++) begin
            exp_line[16*k +: 16] = 16'(k + 1);
            send(32'(k + 1));
        end
        exp_line[95:80] = 16'd6;
        flush = 1'b1;
        send(32'd6);
        flush = 1'b0;
        check("flush6_out_cnt",  {506'd0, out_cnt}, 512'd6);
        check("flush6_out_data", out_data, exp_line);
        step();

        // Flush coincident with the 32nd result yields one full line
        exp_line = '0;
        for (int k = 0; k < 31; k++) begin
            exp_line[16*k +: 16] = 16'(k + 100);
            send(32'(k + 100));
        end
        exp_line[511:496] = 16'd131;
        flush = 1'b1;
        send(32'd131);
        flush = 1'b0;
        check("flush32_out_cnt",  {506'd0, out_cnt}, 512'd32);
        check("flush32_out_data", out_data, exp_line);
        step();
        check("flush32_single", {511'd0, out_vld}, 512'd0);

        // Backpressure: two lines buffered, third pending, 97th dropped
        out_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            exp_lines[j] = '0;
            for (int k = 0; k < 32; k++) begin
                exp_lines[j][16*k +: 16] = 16'(j * 32 + k);
                send(32'(j * 32 + k));
            end
        end
        check("bp_overflow_before", {511'd0, overflow}, 512'd0);
        send(32'd999);
        check("bp_overflow_set", {511'd0, overflow}, 512'd1);
        check("bp_hold_data", out_data, exp_lines[0]);
        check("bp_hold_cnt",  {506'd0, out_cnt}, 512'd32);
        out_rdy = 1'b1;
        check("bp_line0", out_data, exp_lines[0]);
        step();
        check("bp_line1", out_data, exp_lines[1]);
        step();
        check("bp_line2", out_data, exp_lines[2]);
        check("bp_line2_vld", {511'd0, out_vld}, 512'd1);
        step();
        check("bp_drained", {511'd0, out_vld}, 512'd0);
        check("bp_overflow_sticky", {511'd0, overflow}, 512'd1);

        // Reset mid-line discards partial data and clears overflow
        for (int k = 0; k < 10; k++) begin
            send(32'(k + 1000));
        end
        rst      = 1'b1;
        vld_i    = 1'b1;
        flush    = 1'b1;
        result_i = 32'd5555;
        step();
        rst   = 1'b0;
        vld_i = 1'b0;
        flush = 1'b0;
        check("rst_mid_vld",      {511'd0, out_vld},  512'd0);
        check("rst_mid_overflow", {511'd0, overflow}, 512'd0);
        exp_line = '0;
        for (int k = 0; k < 32; k++) begin
            exp_line[16*k +: 16] = 16'(k * 3);
            send(32'(k * 3));
            if (k == 21) check("rst_mid_no_early", {511'd0, out_vld}, 512'd0);
        end
        check("post_rst_out_cnt",  {506'd0, out_cnt}, 512'd32);
        check("post_rst_out_data", out_data, exp_line);
        check("post_rst_overflow", {511'd0, overflow}, 512'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
